// File: rtl/flood_game_ctrl_if.sv
// Signal bundle between the Flood-It sequencer and the UI decoder, board generator, flood engine
// and display. The controller takes the slave view; the surrounding system takes the master view.
interface flood_game_ctrl_if #(
  parameter int CW = 6
);
  logic          START;
  logic [15:0]   SEED_IN;
  logic [4:0]    SIZE_IN;
  logic [3:0]    COLOR_NUM_IN;
  logic [CW-1:0] MOVE_LIMIT;
  logic          MOVE_VALID;
  logic [2:0]    MOVE_COLOR;
  logic [2:0]    CORNER_COLOR;
  logic          BOARD_READY;
  logic          FLOOD_DONE;
  logic          BOARD_UNIFORM;

  logic          INITIALIZE_BOARD;
  logic [15:0]   SEED;
  logic [4:0]    SIZE;
  logic [3:0]    COLOR_NUM;
  logic          FLOOD_START;
  logic [2:0]    FLOOD_COLOR;
  logic [CW-1:0] MOVE_COUNT;
  logic [2:0]    GAME_STATE;
  logic          WIN;
  logic          LOSE;

  modport slave (
    input  START, SEED_IN, SIZE_IN, COLOR_NUM_IN, MOVE_LIMIT, MOVE_VALID, MOVE_COLOR,
           CORNER_COLOR, BOARD_READY, FLOOD_DONE, BOARD_UNIFORM,
    output INITIALIZE_BOARD, SEED, SIZE, COLOR_NUM, FLOOD_START, FLOOD_COLOR, MOVE_COUNT,
           GAME_STATE, WIN, LOSE
  );

  modport master (
    output START, SEED_IN, SIZE_IN, COLOR_NUM_IN, MOVE_LIMIT, MOVE_VALID, MOVE_COLOR,
           CORNER_COLOR, BOARD_READY, FLOOD_DONE, BOARD_UNIFORM,
    input  INITIALIZE_BOARD, SEED, SIZE, COLOR_NUM, FLOOD_START, FLOOD_COLOR, MOVE_COUNT,
           GAME_STATE, WIN, LOSE
  );
endinterface

// File: rtl/flood_game_ctrl.sv
// Flood-It game sequencer: latches the game setup, runs the board-generator handshake, issues
// player moves to the flood engine and decides WIN/LOSE. Define RANDOM_SEED_EN to mix a
// free-running counter into the seed.
module flood_game_ctrl #(
  parameter int MAX_SIZE   = 26,
  parameter int MIN_COLORS = 3,
  parameter int CW         = 6
) (
  input  logic             CLOCK,
  input  logic             RESET,
  flood_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    GEN_REQ = 3'd2,
    GEN_REL = 3'd3,
    PLAY    = 3'd4,
    FLOOD   = 3'd5,
    WON     = 3'd6,
    LOST    = 3'd7
  } state_t;

  localparam logic [4:0]    SIZE_LO   = 5'd2;
  localparam logic [4:0]    SIZE_HI   = 5'(MAX_SIZE);
  localparam logic [3:0]    COLORS_LO = 4'(MIN_COLORS);
  localparam logic [3:0]    COLORS_HI = 4'd8;
  localparam logic [CW-1:0] COUNT_MAX = '1;

  state_t      state;
  logic [4:0]  size_clamped;
  logic [3:0]  colors_clamped;
  logic [15:0] seed_next;
  logic        start_ok;
  logic        move_ok;

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    size_clamped = bus.SIZE_IN;
    if (bus.SIZE_IN < SIZE_LO)      size_clamped = SIZE_LO;
    else if (bus.SIZE_IN > SIZE_HI) size_clamped = SIZE_HI;

    colors_clamped = bus.COLOR_NUM_IN;
    if (bus.COLOR_NUM_IN < COLORS_LO)      colors_clamped = COLORS_LO;
    else if (bus.COLOR_NUM_IN > COLORS_HI) colors_clamped = COLORS_HI;
  end

`ifdef RANDOM_SEED_EN
  logic [15:0] seed_ctr;
  logic [15:0] seed_mix;

  // Free-running entropy source; it never holds 0 so a zero SEED_IN cannot yield a zero seed.
  always_ff @(posedge CLOCK) begin
    if (RESET)                   seed_ctr <= 16'h0001;
    else if (seed_ctr == 16'hFFFF) seed_ctr <= 16'h0001;
    else                         seed_ctr <= seed_ctr + 16'h0001;
  end

  assign seed_mix  = seed_ctr ^ bus.SEED_IN;
  assign seed_next = (seed_mix == 16'h0000) ? 16'h0001 : seed_mix;
`else
  // A zero seed passes through; the generator substitutes its own default.
  assign seed_next = bus.SEED_IN;
`endif

  // START outranks a same-cycle move because start_ok is tested first below.
  assign start_ok = bus.START && (state inside {IDLE, PLAY, WON, LOST});
  assign move_ok  = (state == PLAY) && bus.MOVE_VALID &&
                    ({1'b0, bus.MOVE_COLOR} < bus.COLOR_NUM) &&
                    (bus.MOVE_COLOR != bus.CORNER_COLOR);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state                <= IDLE;
      bus.INITIALIZE_BOARD <= 1'b0;
      bus.SEED             <= 16'h0000;
      bus.SIZE             <= 5'd0;
      bus.COLOR_NUM        <= 4'd0;
      bus.FLOOD_START      <= 1'b0;
      bus.FLOOD_COLOR      <= 3'd0;
      bus.MOVE_COUNT       <= '0;
      bus.WIN              <= 1'b0;
      bus.LOSE             <= 1'b0;
    end else begin
      bus.FLOOD_START <= 1'b0;

      if (start_ok) begin
        bus.SEED       <= seed_next;
        bus.SIZE       <= size_clamped;
        bus.COLOR_NUM  <= colors_clamped;
        bus.MOVE_COUNT <= '0;
        bus.WIN        <= 1'b0;
        bus.LOSE       <= 1'b0;
        // A ready still high from an earlier pass must fall before a fresh request is issued.
        if (bus.BOARD_READY) begin
          state                <= DRAIN;
          bus.INITIALIZE_BOARD <= 1'b0;
        end else begin
          state                <= GEN_REQ;
          bus.INITIALIZE_BOARD <= 1'b1;
        end
      end else begin
        unique case (state)
          DRAIN: begin
            if (!bus.BOARD_READY) begin
              state                <= GEN_REQ;
              bus.INITIALIZE_BOARD <= 1'b1;
            end
          end
          GEN_REQ: begin
            if (bus.BOARD_READY) begin
              state                <= GEN_REL;
              bus.INITIALIZE_BOARD <= 1'b0;
            end
          end
          GEN_REL: begin
            if (!bus.BOARD_READY) state <= PLAY;
          end
          PLAY: begin
            if (move_ok) begin
              bus.FLOOD_START <= 1'b1;
              bus.FLOOD_COLOR <= bus.MOVE_COLOR;
              if (bus.MOVE_COUNT != COUNT_MAX) bus.MOVE_COUNT <= bus.MOVE_COUNT + CW'(1);
              state <= FLOOD;
            end
          end
          FLOOD: begin
            // A uniform board wins even when this was the last allowed move.
            if (bus.FLOOD_DONE) begin
              if (bus.BOARD_UNIFORM) begin
                state   <= WON;
                bus.WIN <= 1'b1;
              end else if ((bus.MOVE_LIMIT != '0) && (bus.MOVE_COUNT >= bus.MOVE_LIMIT)) begin
                state    <= LOST;
                bus.LOSE <= 1'b1;
              end else begin
                state <= PLAY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.GAME_STATE = state;

endmodule
